// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and a sequential clear engine.
// Reads are combinational with optional same-cycle write forwarding; all state changes on the rising edge.
module regfile_mp #(
  parameter int  XLEN   = 32,
  parameter int  NREG   = 32,
  parameter int  NRD    = 4,
  parameter int  NWR    = 2,
  parameter int  BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NRD*AW-1:0]    i_rs_addr,
  output logic [NRD*XLEN-1:0]  o_rs_data,
  output logic [NRD-1:0]       o_rs_busy,
  input  logic [NWR*AW-1:0]    i_rd_addr,
  input  logic [NWR*XLEN-1:0]  i_rd_data,
  input  logic [NWR-1:0]       i_rd_wren,
  input  logic                 i_alloc_en,
  input  logic [AW-1:0]        i_alloc_addr,
  input  logic                 i_clear,
  output logic                 o_clear_busy,
  output logic                 o_wr_conflict
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            clearing;
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] alloc_hit;
  logic [XLEN-1:0] wr_val [NREG];
  logic            conflict_nxt;
  logic            conflict_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_clear) state_nxt = CLEAR;
      CLEAR:   if (cnt == AW'(NREG - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clearing     = (state == CLEAR);
    o_clear_busy = clearing;
  end

  // Counter points at the register being zeroed; starts at 1 since r0 is never stored.
  always_ff @(posedge i_clk) begin
    if (i_reset)            cnt <= '0;
    else if (state == IDLE) cnt <= i_clear ? AW'(1) : '0;
    else                    cnt <= cnt + AW'(1);
  end

  // Per-register write resolution: later (higher) ports override earlier ones.
  always_comb begin
    wr_hit    = '0;
    alloc_hit = '0;
    for (int r = 0; r < NREG; r++) wr_val[r] = '0;
    if (!clearing) begin
      for (int r = 1; r < NREG; r++) begin
        for (int w = 0; w < NWR; w++) begin
          if (i_rd_wren[w] && (i_rd_addr[w*AW +: AW] == AW'(r))) begin
            wr_hit[r] = 1'b1;
            wr_val[r] = i_rd_data[w*XLEN +: XLEN];
          end
        end
        alloc_hit[r] = i_alloc_en && (i_alloc_addr == AW'(r));
      end
    end
  end

  always_comb begin
    conflict_nxt = 1'b0;
    if (!clearing) begin
      for (int i = 0; i < NWR; i++) begin
        for (int j = i + 1; j < NWR; j++) begin
          if (i_rd_wren[i] && i_rd_wren[j] &&
              (i_rd_addr[i*AW +: AW] == i_rd_addr[j*AW +: AW]) &&
              (i_rd_addr[i*AW +: AW] != '0))
            conflict_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) conflict_q <= 1'b0;
    else         conflict_q <= conflict_nxt;
  end

  // A conflict registered on the cycle i_clear was accepted must not leak into CLEAR.
  assign o_wr_conflict = conflict_q && !clearing;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy <= '0;
    end else if (clearing) begin
      regs[cnt] <= '0;
      busy[cnt] <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
        // A new producer issued in the same cycle outranks the retiring write.
        if (alloc_hit[r])   busy[r] <= 1'b1;
        else if (wr_hit[r]) busy[r] <= 1'b0;
      end
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    o_rs_data = '0;
    o_rs_busy = '0;
    ra        = '0;
    if (!clearing) begin
      for (int p = 0; p < NRD; p++) begin
        ra = i_rs_addr[p*AW +: AW];
        if ((ra != '0) && (int'(ra) < NREG)) begin
          if ((BYPASS != 0) && wr_hit[ra]) o_rs_data[p*XLEN +: XLEN] = wr_val[ra];
          else                             o_rs_data[p*XLEN +: XLEN] = regs[ra];
          o_rs_busy[p] = busy[ra] && !((BYPASS != 0) && wr_hit[ra] && !alloc_hit[ra]);
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding and a non-forwarding instance share all inputs.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data, rs_data_nb;
  logic [NRD-1:0]      rs_busy, rs_busy_nb;
  logic [NWR*AW-1:0]   rd_addr;
  logic [NWR*XLEN-1:0] rd_data;
  logic [NWR-1:0]      rd_wren;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                clear;
  logic                clear_busy, clear_busy_nb, wr_conflict, wr_conflict_nb;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_rs_addr(rs_addr), .o_rs_data(rs_data),
    .o_rs_busy(rs_busy), .i_rd_addr(rd_addr), .i_rd_data(rd_data), .i_rd_wren(rd_wren),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .i_clear(clear),
    .o_clear_busy(clear_busy), .o_wr_conflict(wr_conflict));

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nb (
    .i_clk(clk), .i_reset(reset), .i_rs_addr(rs_addr), .o_rs_data(rs_data_nb),
    .o_rs_busy(rs_busy_nb), .i_rd_addr(rd_addr), .i_rd_data(rd_data), .i_rd_wren(rd_wren),
    .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .i_clear(clear),
    .o_clear_busy(clear_busy_nb), .o_wr_conflict(wr_conflict_nb));

  localparam int S_DAT = 0, S_BSY = 1, S_DAT_NB = 2, S_BSY_NB = 3, S_CFL = 4,
                 S_CBSY = 5, S_ANY_DAT = 6, S_ALL_BSY = 7, S_ANY_DAT_NB = 8;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        w0; logic [4:0] a0; logic [31:0] d0;
    logic        w1; logic [4:0] a1; logic [31:0] d1;
    logic        al; logic [4:0] aa;
    logic [4:0]  ra;
    logic [31:0] e_dat; logic [31:0] e_dat_nb;
    logic        e_bsy; logic e_bsy_nb; logic e_cfl;
  } vec_t;

  exp_t sb[$];
  vec_t vt[15];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_DAT:        return rs_data[31:0];
      S_BSY:        return {31'b0, rs_busy[0]};
      S_DAT_NB:     return rs_data_nb[31:0];
      S_BSY_NB:     return {31'b0, rs_busy_nb[0]};
      S_CFL:        return {31'b0, wr_conflict};
      S_CBSY:       return {31'b0, clear_busy};
      S_ANY_DAT:    return {31'b0, |rs_data};
      S_ALL_BSY:    return {28'b0, rs_busy};
      S_ANY_DAT_NB: return {31'b0, |rs_data_nb};
      default:      return '0;
    endcase
  endfunction

  task automatic want(input string nm, input int sel, input logic [31:0] val);
    exp_t e;
    e.nm = nm; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.nm, actual(e.sel), e.val);
    end
  endtask

  task automatic idle();
    rd_wren = '0; rd_addr = '0; rd_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; clear = 1'b0; rs_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    idle();
    rd_wren = {v.w1, v.w0}; rd_addr = {v.a1, v.a0}; rd_data = {v.d1, v.d0};
    alloc_en = v.al; alloc_addr = v.aa; rs_addr = {4{v.ra}};
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // w0 a0 d0 | w1 a1 d1 | al aa | ra | dat dat_nb bsy bsy_nb cfl
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 32'h22, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h22, 32'h22, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3, 32'h33, 32'h0, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 32'h33, 32'h33, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 5'd3, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 32'h44, 32'h33, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 32'h44, 32'h44, 1'b1, 1'b1, 1'b0};
    vt[13] = '{1'b1, 5'd9, 32'hAA, 1'b1, 5'd10, 32'hBB, 1'b0, 5'd0, 5'd10, 32'hBB, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 32'hAA, 32'hAA, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    want("rst_clear_busy", S_CBSY, 32'd0);
    want("rst_conflict", S_CFL, 32'd0);
    drain();
    step();
    reset = 1'b0;

    // All read ports across every register after reset.
    for (int r = 0; r < NREG; r++) begin
      step();
      idle();
      for (int p = 0; p < NRD; p++) rs_addr[p*AW +: AW] = AW'((r + p) % NREG);
      want($sformatf("rst_data_r%0d", r), S_ANY_DAT, 32'd0);
      want($sformatf("rst_busy_r%0d", r), S_ALL_BSY, 32'd0);
      drain();
    end

    for (int i = 0; i < 15; i++) begin
      step();
      drive(vt[i]);
      want($sformatf("v%0d_dat", i), S_DAT, vt[i].e_dat);
      want($sformatf("v%0d_dat_nb", i), S_DAT_NB, vt[i].e_dat_nb);
      want($sformatf("v%0d_bsy", i), S_BSY, {31'b0, vt[i].e_bsy});
      want($sformatf("v%0d_bsy_nb", i), S_BSY_NB, {31'b0, vt[i].e_bsy_nb});
      want($sformatf("v%0d_cfl", i), S_CFL, {31'b0, vt[i].e_cfl});
      drain();
    end

    // Fill r1..r31 with their index, then run a full clear.
    for (int r = 1; r < NREG; r++) begin
      step();
      idle();
      rd_wren = 2'b01; rd_addr[AW-1:0] = AW'(r); rd_data[XLEN-1:0] = 32'(r);
    end
    step();
    idle();
    rs_addr = {4{5'd31}};
    want("fill_r31", S_DAT, 32'd31);
    drain();
    step();
    clear = 1'b1;
    drain();
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!clear_busy) begin
        idle();
        break;
      end
      cyc++;
      idle();
      clear = (cyc <= 5);
      rd_wren = 2'b11; rd_addr = {5'd4, 5'd4}; rd_data = {32'h77, 32'h99};
      alloc_en = 1'b1; alloc_addr = 5'd6;
      rs_addr = {4{5'd31}};
      if (cyc == 3) begin
        want("clear_rd_zero", S_ANY_DAT, 32'd0);
        want("clear_busy_zero", S_ALL_BSY, 32'd0);
        want("clear_no_conflict", S_CFL, 32'd0);
      end
      drain();
    end
    check("clear_cycles", 32'(cyc), 32'd31);
    for (int k = 0; k < NREG / NRD; k++) begin
      step();
      idle();
      for (int p = 0; p < NRD; p++) rs_addr[p*AW +: AW] = AW'(k * NRD + p);
      want($sformatf("post_clear_dat_%0d", k), S_ANY_DAT, 32'd0);
      want($sformatf("post_clear_dat_nb_%0d", k), S_ANY_DAT_NB, 32'd0);
      want($sformatf("post_clear_bsy_%0d", k), S_ALL_BSY, 32'd0);
      want($sformatf("post_clear_cfl_%0d", k), S_CFL, 32'd0);
      drain();
    end

    // Reset in the middle of a clear sequence.
    step();
    idle();
    rd_wren = 2'b11; rd_addr = {5'd2, 5'd20}; rd_data = {32'h5678, 32'h1234};
    alloc_en = 1'b1; alloc_addr = 5'd21;
    step();
    idle();
    rs_addr = {4{5'd20}};
    want("pre_rst_r20", S_DAT, 32'h1234);
    drain();
    step();
    clear = 1'b1;
    drain();
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (!clear_busy) break;
      cyc++;
      clear = 1'b0;
      if (cyc == 10) begin
        reset = 1'b1;
        break;
      end
    end
    step();
    reset = 1'b0;
    idle();
    rs_addr = {5'd0, 5'd2, 5'd21, 5'd20};
    check("mid_clear_cycles", 32'(cyc), 32'd10);
    want("mid_rst_clear_busy", S_CBSY, 32'd0);
    want("mid_rst_data", S_ANY_DAT, 32'd0);
    want("mid_rst_busy", S_ALL_BSY, 32'd0);
    drain();
    step();
    idle();
    rd_wren = 2'b01; rd_addr[AW-1:0] = 5'd20; rd_data[XLEN-1:0] = 32'h5A5A;
    drain();
    step();
    idle();
    rs_addr = {4{5'd20}};
    want("post_rst_wr", S_DAT, 32'h5A5A);
    want("post_rst_wr_nb", S_DAT_NB, 32'h5A5A);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
